// File: rtl/sample8_pkg.sv
// Shared widths, output-state encoding and a sign-extension helper for the
// sample_gather8 front end and its adder12s consumer.
package sample8_pkg;

    localparam int unsigned SMP_W = 12;
    localparam int unsigned SMP_N = 8;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned SUM_W = 15;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_st_e;

    function automatic logic [SUM_W-1:0] sext_smp(input logic [SMP_W-1:0] v);
        return {{(SUM_W - SMP_W){v[SMP_W-1]}}, v};
    endfunction

endpackage

// File: rtl/adder12s.sv
// Eight-input signed 12-bit summer with a 15-bit two's complement result.
module adder12s
    import sample8_pkg::*;
(
    input  logic [SMP_W-1:0] n0_i,
    input  logic [SMP_W-1:0] n1_i,
    input  logic [SMP_W-1:0] n2_i,
    input  logic [SMP_W-1:0] n3_i,
    input  logic [SMP_W-1:0] n4_i,
    input  logic [SMP_W-1:0] n5_i,
    input  logic [SMP_W-1:0] n6_i,
    input  logic [SMP_W-1:0] n7_i,
    output logic [SUM_W-1:0] sum_o
);

    assign sum_o = sext_smp(n0_i) + sext_smp(n1_i) + sext_smp(n2_i) + sext_smp(n3_i)
                 + sext_smp(n4_i) + sext_smp(n5_i) + sext_smp(n6_i) + sext_smp(n7_i);

endmodule

// File: rtl/gather_ctrl.sv
// Control for sample_gather8: capture slot counter, EMPTY/FULL output state,
// input back-pressure and the capture / frame-load strobes.
module gather_ctrl
    import sample8_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    input  logic             out_ready_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [SMP_N-1:0] cap_we_o,
    output logic             frame_load_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    out_st_e          state_q, state_d;
    logic             last_slot;
    logic             accept;

    assign last_slot = (cnt_q == CNT_W'(SMP_N - 1));

    // Only stall when the closing sample would overwrite an unconsumed frame.
    assign in_ready_o   = ~flush_i & ~(last_slot & (state_q == ST_FULL) & ~out_ready_i);
    assign accept       = in_valid_i & in_ready_o;
    assign frame_load_o = accept & last_slot;
    assign cap_we_o     = accept ? (SMP_N'(1) << cnt_q) : '0;
    assign out_valid_o  = (state_q == ST_FULL);

    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        if (flush_i) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = last_slot ? '0 : cnt_q + 1'b1;
        end
        unique case (state_q)
            ST_EMPTY: if (frame_load_o) state_d = ST_FULL;
            ST_FULL:  if (out_ready_i && !frame_load_o) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            state_q <= ST_EMPTY;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/sample_gather8.sv
// Serial-to-parallel, double-buffered packer: eight signed samples per frame,
// presented on n0..n7 (n0 oldest) behind a valid/ready handshake.
module sample_gather8
    import sample8_pkg::*;
#(
    parameter int unsigned WIDTH = SMP_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] n0_o,
    output logic [WIDTH-1:0] n1_o,
    output logic [WIDTH-1:0] n2_o,
    output logic [WIDTH-1:0] n3_o,
    output logic [WIDTH-1:0] n4_o,
    output logic [WIDTH-1:0] n5_o,
    output logic [WIDTH-1:0] n6_o,
    output logic [WIDTH-1:0] n7_o
);

    logic [SMP_N-1:0] cap_we;
    logic             frame_load;
    logic [WIDTH-1:0] cap_q [SMP_N];
    logic [WIDTH-1:0] out_q [SMP_N];

    gather_ctrl u_ctrl (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .in_valid_i   (in_valid_i),
        .out_ready_i  (out_ready_i),
        .in_ready_o   (in_ready_o),
        .out_valid_o  (out_valid_o),
        .cap_we_o     (cap_we),
        .frame_load_o (frame_load)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < SMP_N; i++) cap_q[i] <= '0;
        end else begin
            for (int i = 0; i < SMP_N; i++) begin
                if (cap_we[i]) cap_q[i] <= in_data_i;
            end
        end
    end

    // The closing sample bypasses its capture slot straight into n7.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < SMP_N; i++) out_q[i] <= '0;
        end else if (frame_load) begin
            for (int i = 0; i < SMP_N - 1; i++) out_q[i] <= cap_q[i];
            out_q[SMP_N-1] <= in_data_i;
        end
    end

    assign n0_o = out_q[0];
    assign n1_o = out_q[1];
    assign n2_o = out_q[2];
    assign n3_o = out_q[3];
    assign n4_o = out_q[4];
    assign n5_o = out_q[5];
    assign n6_o = out_q[6];
    assign n7_o = out_q[7];

endmodule

// File: tb/tb_sample_gather8.sv
// Directed scenarios plus a random phase for sample_gather8, checked against a
// queue-based frame model; adder12s on n0..n7 checks the frame sum.
module tb_sample_gather8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [11:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [11:0] n0, n1, n2, n3, n4, n5, n6, n7;
    logic [14:0] sum;

    always #10 clk = ~clk;

    sample_gather8 dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .n0_o        (n0),
        .n1_o        (n1),
        .n2_o        (n2),
        .n3_o        (n3),
        .n4_o        (n4),
        .n5_o        (n5),
        .n6_o        (n6),
        .n7_o        (n7)
    );

    adder12s u_add (
        .n0_i  (n0),
        .n1_i  (n1),
        .n2_i  (n2),
        .n3_i  (n3),
        .n4_i  (n4),
        .n5_i  (n5),
        .n6_i  (n6),
        .n7_i  (n7),
        .sum_o (sum)
    );

    // Reference model: accepted samples queue up until eight form a frame.
    logic [11:0] partial[$];
    logic [11:0] exp_n [8];
    logic        exp_valid;
    logic        last_acc;
    int          vectors = 0;
    int          miscompares = 0;

    wire [95:0] n_all = {n7, n6, n5, n4, n3, n2, n1, n0};

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] exp_all();
        logic [95:0] r;
        for (int i = 0; i < 8; i++) r[i*12 +: 12] = exp_n[i];
        return r;
    endfunction

    function automatic logic [14:0] exp_sum();
        int s = 0;
        for (int i = 0; i < 8; i++) s += int'($signed(exp_n[i]));
        return 15'(s);
    endfunction

    function automatic void model_reset();
        partial.delete();
        exp_valid = 1'b0;
        for (int i = 0; i < 8; i++) exp_n[i] = '0;
    endfunction

    // One clock: drive at negedge, check before the edge, update model after it.
    task automatic step(input logic v, input logic [11:0] d, input logic rdy, input logic f);
        logic exp_ready, acc, loaded;
        in_valid = v; in_data = d; out_ready = rdy; flush = f;
        #1;
        exp_ready = !f && !(partial.size() == 7 && exp_valid && !rdy);
        chk("in_ready", 96'(in_ready), 96'(exp_ready));
        chk("out_valid", 96'(out_valid), 96'(exp_valid));
        chk("frame", n_all, exp_all());
        chk("sum", 96'(sum), 96'(exp_sum()));
        acc = v && exp_ready;
        last_acc = acc;
        loaded = 1'b0;
        @(posedge clk);
        if (f) partial.delete();
        if (acc) begin
            partial.push_back(d);
            if (partial.size() == 8) begin
                for (int i = 0; i < 8; i++) exp_n[i] = partial[i];
                partial.delete();
                exp_valid = 1'b1;
                loaded = 1'b1;
            end
        end
        if (exp_valid && rdy && !loaded) exp_valid = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b0;
        in_data = 12'($urandom);
    endtask

    task automatic send(input logic [11:0] d, input logic rdy);
        int tries = 0;
        do begin
            step(1'b1, d, rdy, 1'b0);
            tries++;
        end while (!last_acc && tries < 16);
        if (!last_acc) begin
            vectors++;
            miscompares++;
            $error("FAIL send_timeout observed=stalled expected=accepted data=%0h", d);
        end
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 12'($urandom), rdy, 1'b0);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", 96'(out_valid), 96'(1'b0));
        chk("rst_frame", n_all, 96'(0));
        rst = 1'b0;
        @(negedge clk);

        // Streaming with out_ready held high.
        for (int i = 0; i < 8; i++) send(12'hFFF, 1'b1);
        chk("s2_sum_fff", 96'(sum), 96'(15'h7FF8));
        for (int i = 0; i < 8; i++) send(12'h7FF, 1'b1);
        chk("s2_sum_7ff", 96'(sum), 96'(15'h3FF8));
        idle(1'b1, 2);

        // Reset mid-frame.
        for (int i = 0; i < 3; i++) send(12'h123 + 12'(i), 1'b1);
        rst = 1'b1;
        #1;
        chk("s1_out_valid", 96'(out_valid), 96'(1'b0));
        chk("s1_frame", n_all, 96'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) send(12'h010 + 12'(i), 1'b1);
        chk("s1_n0", 96'(n0), 96'(12'h010));
        idle(1'b1, 1);

        // Backpressure.
        for (int i = 0; i < 8; i++) send(12'h800, 1'b0);
        chk("s3_sum_800", 96'(sum), 96'(15'h4000));
        for (int i = 0; i < 7; i++) send(12'h001, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 12'h001, 1'b0, 1'b0);
        chk("s3_held_sum", 96'(sum), 96'(15'h4000));
        send(12'h001, 1'b1);
        chk("s3_sum_001", 96'(sum), 96'(15'h0008));
        idle(1'b1, 1);

        // Ordering.
        for (int i = 0; i < 8; i++) send((i % 2 == 0) ? 12'h001 : 12'hFFF, 1'b1);
        chk("s4_n1", 96'(n1), 96'(12'hFFF));
        chk("s4_sum", 96'(sum), 96'(15'h0000));
        for (int i = 0; i < 8; i++) send((i % 2 == 0) ? 12'hAAA : 12'h555, 1'b1);
        chk("s4_sum_aa55", 96'(sum), 96'(15'h7FFC));
        idle(1'b1, 1);

        // Flush discards the partial frame; the flush-cycle sample is ignored.
        for (int i = 0; i < 4; i++) send(12'h7FF, 1'b1);
        step(1'b1, 12'h3C3, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) send(12'h7FF, 1'b1);
        for (int i = 0; i < 4; i++) send(12'h801, 1'b1);
        chk("s5_n4", 96'(n4), 96'(12'h801));
        chk("s5_sum", 96'(sum), 96'(15'h0000));
        idle(1'b1, 1);

        // Consumer takes the old frame on the same edge the new one completes.
        for (int i = 0; i < 8; i++) send(12'h100 + 12'(i), 1'b0);
        for (int i = 0; i < 7; i++) send(12'h200 + 12'(i), 1'b0);
        send(12'h207, 1'b1);
        chk("s6_valid", 96'(out_valid), 96'(1'b1));
        chk("s6_n7", 96'(n7), 96'(12'h207));
        idle(1'b0, 2);
        idle(1'b1, 2);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 12'($urandom), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 23) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
